// File: rtl/aes_cipher_iter.sv
// Iterative AES encryption core: one cipher round per clock on a 128-bit state register.
// Optional macro AES_CIPHER_ZEROIZE_EN clears the state and the ciphertext after each block.
module aes_cipher_iter #(
  parameter int unsigned Nk = 4,
  parameter int unsigned Nr = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Start,
  input  logic [0:127]          Data_in,
  input  logic [0:128*(Nr+1)-1] Word,
  output logic                  Busy,
  output logic                  Done,
  output logic [0:127]          Data_out
);

  if (Nr != Nk + 6) begin : g_cfg_check
    $error("aes_cipher_iter: Nr must equal Nk+6");
  end

  typedef enum logic [0:0] {StIdle, StRun} fsm_e;

  localparam logic [3:0] LastRnd = 4'(Nr);

  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] a);
    return SBOX[{a, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte 4c+r holds s[r][c]; row r of the output takes column (c+r)%4 of the input.
  function automatic logic [0:127] sub_shift(input logic [0:127] s);
    logic [0:127] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[8*(4*c+r) +: 8] = sbox(s[8*(4*((c+r)%4)+r) +: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [0:127] mix_columns(input logic [0:127] s);
    logic [0:127] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c    +: 8];
      a1 = s[32*c+8  +: 8];
      a2 = s[32*c+16 +: 8];
      a3 = s[32*c+24 +: 8];
      o[32*c    +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[32*c+8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[32*c+16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[32*c+24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  fsm_e         r_fsm, w_fsm_d;
  logic [0:127] r_state, w_state_d;
  logic [3:0]   r_rnd, w_rnd_d;
  logic         r_busy, w_busy_d;
  logic         r_done, w_done_d;
  logic [0:127] r_dout, w_dout_d;

  logic [0:127] w_sr;
  logic [0:127] w_mc;
  logic [0:127] w_rkey;

  // Round key is read live from the schedule every cycle; it is never latched.
  assign w_rkey = Word[{r_rnd, 7'b0000000} +: 128];
  assign w_sr   = sub_shift(r_state);
  assign w_mc   = mix_columns(w_sr);

  always_comb begin
    w_fsm_d   = r_fsm;
    w_state_d = r_state;
    w_rnd_d   = r_rnd;
    w_busy_d  = r_busy;
    w_done_d  = 1'b0;
    w_dout_d  = r_dout;
`ifdef AES_CIPHER_ZEROIZE_EN
    if (r_done) begin
      w_dout_d = '0;
    end
`endif
    case (r_fsm)
      StIdle: begin
        if (Start) begin
          w_state_d = Data_in ^ Word[0 +: 128];
          w_rnd_d   = 4'd1;
          w_busy_d  = 1'b1;
          w_fsm_d   = StRun;
        end
      end
      StRun: begin
        if (r_rnd == LastRnd) begin
          w_dout_d = w_sr ^ w_rkey;
          w_done_d = 1'b1;
          w_busy_d = 1'b0;
          w_fsm_d  = StIdle;
`ifdef AES_CIPHER_ZEROIZE_EN
          w_state_d = '0;
`endif
        end else begin
          w_state_d = w_mc ^ w_rkey;
          w_rnd_d   = r_rnd + 4'd1;
        end
      end
      default: w_fsm_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm   <= StIdle;
      r_state <= '0;
      r_rnd   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dout  <= '0;
    end else begin
      r_fsm   <= w_fsm_d;
      r_state <= w_state_d;
      r_rnd   <= w_rnd_d;
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
      r_dout  <= w_dout_d;
    end
  end

  assign Busy     = r_busy;
  assign Done     = r_done;
  assign Data_out = r_dout;

endmodule
